// File: rtl/motor_pwm_ramp.sv
// Single H-bridge channel: slew-limited duty command, reversal through zero with a dead time,
// and a glitch-free PWM generator that only picks up a new duty at the start of a period.
module motor_pwm_ramp #(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 195,
    parameter int RAMP_DIV    = 50000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic                cmd_dir,
    input  logic                estop,
    output logic                PWM_Out,
    output logic                dir,
    output logic [PWM_BITS-1:0] cur_duty,
    output logic                at_target
);

    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam int PRE_W  = $clog2(PRESCALE + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DECEL = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PWM_BITS-1:0] cur_duty_q, cur_duty_d;
    logic [PWM_BITS-1:0] tgt_duty_q, tgt_duty_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic                dir_q, dir_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_latch_q, duty_latch_d;
    logic                pwm_q, pwm_d;
    logic                ramp_tick, pre_tick, pwm_kill;

    always_comb begin
        ramp_tick  = (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
        ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RAMP_W'(1);
        pre_tick   = (pre_cnt_q == PRE_W'(PRESCALE - 1));
        pre_cnt_d  = pre_tick ? '0 : pre_cnt_q + PRE_W'(1);
        cnt_d      = pre_tick ? cnt_q + PWM_BITS'(1) : cnt_q;

        tgt_duty_d = cmd_valid ? cmd_duty : tgt_duty_q;
        tgt_dir_d  = cmd_valid ? cmd_dir  : tgt_dir_q;

        state_d    = state_q;
        cur_duty_d = cur_duty_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;

        if (estop) begin
            cur_duty_d = '0;
            if (dir_q != tgt_dir_q) begin
                state_d    = ST_DEAD;
                dead_cnt_d = DEAD_W'(DEAD_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tgt_dir_q != dir_q) begin
                        state_d = ST_DECEL;
                    end else if (ramp_tick) begin
                        if (cur_duty_q < tgt_duty_q)
                            cur_duty_d = cur_duty_q + PWM_BITS'(1);
                        else if (cur_duty_q > tgt_duty_q)
                            cur_duty_d = cur_duty_q - PWM_BITS'(1);
                    end
                end
                ST_DECEL: begin
                    if (tgt_dir_q == dir_q) begin
                        state_d = ST_RUN;
                    end else if (cur_duty_q == '0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DEAD_W'(DEAD_CYCLES - 1);
                    end else if (ramp_tick) begin
                        cur_duty_d = cur_duty_q - PWM_BITS'(1);
                    end
                end
                ST_DEAD: begin
                    cur_duty_d = '0;
                    if (dead_cnt_q == '0) begin
                        dir_d   = tgt_dir_q;
                        state_d = ST_RUN;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // Dead time and estop clear the latch too, so a stale period can't pulse the pin afterwards.
        pwm_kill     = estop || (state_d == ST_DEAD);
        duty_latch_d = duty_latch_q;
        if (pwm_kill)
            duty_latch_d = '0;
        else if (pre_tick && (cnt_q == '1))
            duty_latch_d = cur_duty_q;
        pwm_d = pwm_kill ? 1'b0 : (cnt_q < duty_latch_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cur_duty_q   <= '0;
            tgt_duty_q   <= '0;
            tgt_dir_q    <= 1'b0;
            dir_q        <= 1'b0;
            dead_cnt_q   <= '0;
            ramp_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            duty_latch_q <= '0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_duty_q   <= cur_duty_d;
            tgt_duty_q   <= tgt_duty_d;
            tgt_dir_q    <= tgt_dir_d;
            dir_q        <= dir_d;
            dead_cnt_q   <= dead_cnt_d;
            ramp_cnt_q   <= ramp_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            duty_latch_q <= duty_latch_d;
            pwm_q        <= pwm_d;
        end
    end

    assign PWM_Out   = pwm_q;
    assign dir       = dir_q;
    assign cur_duty  = cur_duty_q;
    assign at_target = (state_q == ST_RUN) && (cur_duty_q == tgt_duty_q) && (dir_q == tgt_dir_q);

endmodule
